// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the parametrised ID-stage hazard unit.
//   - hz_state_e : FSM state encodings (RUN..BUSY), exported on state_o.
//   - CODE_*     : 4-bit cause codes carried in the low nibble of stall_output.
//   - cause_word : widens a cause code to the 32-bit debug bus.
package hazard_pkg;

  typedef enum logic [2:0] {
    ST_RUN          = 3'd0,
    ST_LOAD_STALL   = 3'd1,
    ST_BRANCH_STALL = 3'd2,
    ST_FLUSH        = 3'd3,
    ST_BUSY         = 3'd4
  } hz_state_e;

  localparam logic [3:0] CODE_NONE   = 4'h0;
  localparam logic [3:0] CODE_LOAD   = 4'h1;
  localparam logic [3:0] CODE_ADDR   = 4'hA;
  localparam logic [3:0] CODE_BRANCH = 4'hB;
  localparam logic [3:0] CODE_BUSY   = 4'hC;
  localparam logic [3:0] CODE_FLUSH  = 4'hF;

  function automatic logic [31:0] cause_word(input logic [3:0] code);
    return {28'd0, code};
  endfunction

endpackage

// File: rtl/hazard_unit_param_if.sv
// hazard_unit_param_if: groups the pipeline-side signals of the hazard unit.
//   master : pipeline (drives ID/EX fields, receives stall/flush controls)
//   slave  : hazard unit (reads ID/EX fields, drives controls and debug)
// Fields: rs1_ID, rs2_ID, rs1_used, rs2_used, rd_EX, WB_sel, auipc_EX,
//         ext_busy, branch_ID, branch_taken  (pipeline -> hazard unit)
//         stall_IFID, stall_IDEX, flush, stall_output[31:0], state_o[2:0]
//                                             (hazard unit -> pipeline)
interface hazard_unit_param_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic              rs1_used;
  logic              rs2_used;
  logic [REG_AW-1:0] rd_EX;
  logic              WB_sel;
  logic              auipc_EX;
  logic              ext_busy;
  logic              branch_ID;
  logic              branch_taken;
  logic              stall_IFID;
  logic              stall_IDEX;
  logic              flush;
  logic [31:0]       stall_output;
  logic [2:0]        state_o;

  modport master (
    output rs1_ID, rs2_ID, rs1_used, rs2_used, rd_EX, WB_sel, auipc_EX,
           ext_busy, branch_ID, branch_taken,
    input  stall_IFID, stall_IDEX, flush, stall_output, state_o
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_used, rs2_used, rd_EX, WB_sel, auipc_EX,
           ext_busy, branch_ID, branch_taken,
    output stall_IFID, stall_IDEX, flush, stall_output, state_o
  );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: combinational source/destination comparator.
//   rs1, rs2, rs1_used, rs2_used : sources of the consuming instruction
//   rd                           : destination of the producing instruction
//   is_load, is_auipc            : producer type
//   m1, m2                       : per-source dependency (x0 never matches)
//   ld_haz, au_haz               : load-use and auipc address hazards
module hazard_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] rd,
  input  logic              is_load,
  input  logic              is_auipc,
  output logic              m1,
  output logic              m2,
  output logic              ld_haz,
  output logic              au_haz
);
  logic rd_nz;

  assign rd_nz  = (rd != '0);
  assign m1     = rs1_used && (rs1 == rd) && rd_nz;
  assign m2     = rs2_used && (rs2 == rd) && rd_nz;
  assign ld_haz = is_load && (m1 || m2);
  // auipc forms an address from rs1 only, so rs2 never creates this hazard
  assign au_haz = is_auipc && m1;
endmodule

// File: rtl/hazard_unit_param.sv
// hazard_unit_param: ID-stage hazard unit with FSM-sequenced stall/flush.
// Ports:
//   clock, reset (async, active-low)
//   hz : hazard_unit_param_if.slave (ID/EX fields in, stall/flush/debug out)
// Build option HAZARD_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt,
// free-running 32-bit counts of stall and flush cycles, cleared by reset.
module hazard_unit_param
  import hazard_pkg::*;
#(
  parameter int REG_AW           = 5,
  parameter int LOAD_STALL_CYC   = 2,
  parameter int BRANCH_STALL_CYC = 1,
  parameter int FLUSH_CYC        = 1,
  parameter int CNT_W            = 4
) (
  input  logic               clock,
  input  logic               reset,
  hazard_unit_param_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m1, m2, ld_haz, au_haz;
  logic             run_eval;
  logic             stall, flush;
  logic [3:0]       code;

  hazard_match #(.REG_AW(REG_AW)) u_match (
    .rs1      (hz.rs1_ID),
    .rs2      (hz.rs2_ID),
    .rs1_used (hz.rs1_used),
    .rs2_used (hz.rs2_used),
    .rd       (hz.rd_EX),
    .is_load  (hz.WB_sel),
    .is_auipc (hz.auipc_EX),
    .m1       (m1),
    .m2       (m2),
    .ld_haz   (ld_haz),
    .au_haz   (au_haz)
  );

  // BUSY with the unit released is evaluated exactly like RUN in that cycle
  assign run_eval = (state_q == ST_RUN) || ((state_q == ST_BUSY) && !hz.ext_busy);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt holds remaining cycles after the current one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz.branch_taken) begin
      if (FLUSH_CYC > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = CNT_W'(FLUSH_CYC - 2);
      end else begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else if (state_q == ST_LOAD_STALL || state_q == ST_BRANCH_STALL ||
                 state_q == ST_FLUSH) begin
      if (cnt_q == '0) state_d = ST_RUN;
      else             cnt_d   = cnt_q - CNT_W'(1);
    end else if (state_q == ST_BUSY && hz.ext_busy) begin
      state_d = ST_BUSY;
    end else if (run_eval) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      if (ld_haz) begin
        if (LOAD_STALL_CYC > 1) begin
          state_d = ST_LOAD_STALL;
          cnt_d   = CNT_W'(LOAD_STALL_CYC - 2);
        end
      end else if (au_haz) begin
        state_d = ST_RUN;
      end else if (hz.ext_busy) begin
        state_d = ST_BUSY;
      end else if (hz.branch_ID) begin
        if (BRANCH_STALL_CYC > 1) begin
          state_d = ST_BRANCH_STALL;
          cnt_d   = CNT_W'(BRANCH_STALL_CYC - 2);
        end
      end
    end else begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end
  end

  // Output logic; reset low masks everything so outputs read 0 during reset
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    code  = CODE_NONE;
    if (!reset) begin
      code = CODE_NONE;
    end else if (hz.branch_taken) begin
      flush = 1'b1;
      code  = CODE_FLUSH;
    end else if (state_q == ST_LOAD_STALL) begin
      stall = 1'b1;
      code  = CODE_LOAD;
    end else if (state_q == ST_BRANCH_STALL) begin
      stall = 1'b1;
      code  = CODE_BRANCH;
    end else if (state_q == ST_FLUSH) begin
      flush = 1'b1;
      code  = CODE_FLUSH;
    end else if (state_q == ST_BUSY && hz.ext_busy) begin
      stall = 1'b1;
      code  = CODE_BUSY;
    end else if (run_eval) begin
      if (ld_haz) begin
        stall = 1'b1;
        code  = CODE_LOAD;
      end else if (au_haz) begin
        stall = 1'b1;
        code  = CODE_ADDR;
      end else if (hz.ext_busy) begin
        stall = 1'b1;
        code  = CODE_BUSY;
      end else if (hz.branch_ID) begin
        stall = 1'b1;
        code  = CODE_BRANCH;
      end
    end
  end

  assign hz.stall_IFID   = stall;
  assign hz.stall_IDEX   = stall;
  assign hz.flush        = flush;
  assign hz.stall_output = cause_word(code);
  assign hz.state_o      = reset ? state_q : ST_RUN;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_param.sv
// tb_hazard_unit_param: scoreboard bench for hazard_unit_param with
// LOAD_STALL_CYC=3, BRANCH_STALL_CYC=2, FLUSH_CYC=2.
module tb_hazard_unit_param;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] code;
    logic [2:0]  state;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  hazard_unit_param_if #(.REG_AW(5)) hz ();

  hazard_unit_param #(
    .REG_AW           (5),
    .LOAD_STALL_CYC   (3),
    .BRANCH_STALL_CYC (2),
    .FLUSH_CYC        (2),
    .CNT_W            (4)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .hz    (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_in();
    hz.rs1_ID = '0; hz.rs2_ID = '0; hz.rs1_used = 1'b0; hz.rs2_used = 1'b0;
    hz.rd_EX = '0; hz.WB_sel = 1'b0; hz.auipc_EX = 1'b0; hz.ext_busy = 1'b0;
    hz.branch_ID = 1'b0; hz.branch_taken = 1'b0;
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  // Push the expectation for the current cycle, let inputs settle, then
  // pop it and compare against what the DUT presents.
  task automatic expect_out(input string tag, input logic st, input logic fl,
                            input logic [3:0] code, input logic [2:0] state);
    exp_t e, p;
    e.stall = st; e.flush = fl; e.code = {28'd0, code}; e.state = state;
    exp_q.push_back(e);
    #1;
    p = exp_q.pop_front();
    check_val({tag, ".stall_IFID"},   {31'd0, hz.stall_IFID}, {31'd0, p.stall});
    check_val({tag, ".stall_IDEX"},   {31'd0, hz.stall_IDEX}, {31'd0, p.stall});
    check_val({tag, ".flush"},        {31'd0, hz.flush},      {31'd0, p.flush});
    check_val({tag, ".stall_output"}, hz.stall_output,        p.code);
    check_val({tag, ".state_o"},      {29'd0, hz.state_o},    {29'd0, p.state});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clr_in();

    // Reset state, with a branch pending that must be masked
    next_cyc(); hz.branch_ID = 1'b1;
    expect_out("reset", 0, 0, 4'h0, 3'd0);
    rst_n = 1'b1; clr_in();
    next_cyc(); expect_out("idle", 0, 0, 4'h0, 3'd0);

    // Load-use on rs2: exactly 3 stall cycles, state 0->1->1->0
    next_cyc(); hz.WB_sel = 1'b1; hz.rd_EX = 5'd5; hz.rs2_ID = 5'd5; hz.rs2_used = 1'b1;
    expect_out("ld_c1", 1, 0, 4'h1, 3'd0);
    next_cyc(); expect_out("ld_c2", 1, 0, 4'h1, 3'd1);
    next_cyc(); expect_out("ld_c3", 1, 0, 4'h1, 3'd1);
    next_cyc(); clr_in(); expect_out("ld_end", 0, 0, 4'h0, 3'd0);

    // rd_EX = 0 never matches; unused rs1 never matches
    next_cyc(); hz.WB_sel = 1'b1; hz.rd_EX = 5'd0; hz.rs1_ID = 5'd0; hz.rs1_used = 1'b1;
    expect_out("rd_zero", 0, 0, 4'h0, 3'd0);
    next_cyc(); hz.rd_EX = 5'd5; hz.rs1_ID = 5'd5; hz.rs1_used = 1'b0;
    expect_out("rs1_unused", 0, 0, 4'h0, 3'd0);

    // auipc with rs1 match: one-cycle stall, stays in RUN
    next_cyc(); clr_in(); hz.auipc_EX = 1'b1; hz.rd_EX = 5'd7; hz.rs1_ID = 5'd7; hz.rs1_used = 1'b1;
    expect_out("au_c1", 1, 0, 4'hA, 3'd0);
    next_cyc(); clr_in(); expect_out("au_end", 0, 0, 4'h0, 3'd0);
    // auipc with only rs2 matching: no hazard
    next_cyc(); hz.auipc_EX = 1'b1; hz.rd_EX = 5'd7; hz.rs1_ID = 5'd3; hz.rs1_used = 1'b1;
    hz.rs2_ID = 5'd7; hz.rs2_used = 1'b1;
    expect_out("au_rs2", 0, 0, 4'h0, 3'd0);

    // branch_taken aborts LOAD_STALL in its 2nd cycle
    next_cyc(); clr_in(); hz.WB_sel = 1'b1; hz.rd_EX = 5'd9; hz.rs1_ID = 5'd9; hz.rs1_used = 1'b1;
    expect_out("ab_c1", 1, 0, 4'h1, 3'd0);
    next_cyc(); hz.branch_taken = 1'b1;
    expect_out("ab_c2", 0, 1, 4'hF, 3'd1);
    next_cyc(); clr_in(); expect_out("ab_c3", 0, 1, 4'hF, 3'd3);
    next_cyc(); expect_out("ab_end", 0, 0, 4'h0, 3'd0);

    // branch_taken outranks a simultaneous load-use in RUN
    next_cyc(); hz.WB_sel = 1'b1; hz.rd_EX = 5'd4; hz.rs2_ID = 5'd4; hz.rs2_used = 1'b1;
    hz.branch_taken = 1'b1;
    expect_out("bt_c1", 0, 1, 4'hF, 3'd0);
    next_cyc(); clr_in(); expect_out("bt_c2", 0, 1, 4'hF, 3'd3);
    next_cyc(); expect_out("bt_end", 0, 0, 4'h0, 3'd0);

    // ext_busy for 4 cycles with a branch waiting, then branch stall
    next_cyc(); hz.ext_busy = 1'b1; hz.branch_ID = 1'b1;
    expect_out("bz_c1", 1, 0, 4'hC, 3'd0);
    for (int i = 2; i <= 4; i++) begin
      next_cyc(); expect_out($sformatf("bz_c%0d", i), 1, 0, 4'hC, 3'd4);
    end
    next_cyc(); hz.ext_busy = 1'b0;
    expect_out("br_c1", 1, 0, 4'hB, 3'd4);
    next_cyc(); hz.branch_ID = 1'b0;
    expect_out("br_c2", 1, 0, 4'hB, 3'd2);
    next_cyc(); expect_out("br_end", 0, 0, 4'h0, 3'd0);

    // Asynchronous reset in the middle of BRANCH_STALL
    next_cyc(); hz.branch_ID = 1'b1;
    expect_out("ar_c1", 1, 0, 4'hB, 3'd0);
    next_cyc(); expect_out("ar_c2", 1, 0, 4'hB, 3'd2);
    #2 rst_n = 1'b0;
    expect_out("ar_rst", 0, 0, 4'h0, 3'd0);
    next_cyc(); rst_n = 1'b1; clr_in();
    expect_out("ar_rel", 0, 0, 4'h0, 3'd0);
    next_cyc(); expect_out("ar_idle", 0, 0, 4'h0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
